// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One pipeline stage per CHUNK-bit slice.
  function automatic int unsigned stages_of(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned chunk);
    return idx * chunk;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module rca_chunk
  import rca_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = ci;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    co    = carry[CHUNK];
    c_msb = carry[CHUNK-1];
  end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per stage, global valid/ready stall.
// Optional zero/neg result flags are built when RCA_PIPE_FLAGS_EN is defined.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
`ifdef RCA_PIPE_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int unsigned STAGES = stages_of(WIDTH, CHUNK);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $fatal(1, "rca_pipe: WIDTH must be a multiple of CHUNK");
  end

  logic adv_c;
  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;

  // Stage boundary k carries the operands/partial sum entering stage k.
  logic             v_s   [STAGES];
  logic             c_s   [STAGES];
  logic [WIDTH-1:0] a_s   [STAGES];
  logic [WIDTH-1:0] b_s   [STAGES];
  logic [WIDTH-1:0] sum_s [STAGES];

  assign v_s[0]   = in_valid;
  assign a_s[0]   = a;
  assign b_s[0]   = (sub == OP_SUB) ? ~b : b;
  assign c_s[0]   = (sub == OP_SUB) ? 1'b1 : cin;
  assign sum_s[0] = '0;

  logic             last_v;
  logic [WIDTH-1:0] last_sum;
  logic             last_co;
  logic             last_cm;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned LO = slice_lo(32'(k), CHUNK);

    logic [CHUNK-1:0] slice_s;
    logic             co;
    logic             cm;

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_s[k][LO +: CHUNK]),
      .b     (b_s[k][LO +: CHUNK]),
      .ci    (c_s[k]),
      .s     (slice_s),
      .co    (co),
      .c_msb (cm)
    );

    if (k < int'(STAGES) - 1) begin : g_reg
      logic             v_q,   v_d;
      logic             c_q,   c_d;
      logic [WIDTH-1:0] a_q,   a_d;
      logic [WIDTH-1:0] b_q,   b_d;
      logic [WIDTH-1:0] sum_q, sum_d;
      logic             cm_unused;

      assign cm_unused = cm;

      always_comb begin
        v_d   = v_q;
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        if (adv_c) begin
          v_d = v_s[k];
          if (v_s[k]) begin
            c_d   = co;
            a_d   = a_s[k];
            b_d   = b_s[k];
            sum_d = sum_s[k];
            sum_d[LO +: CHUNK] = slice_s;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
        end else begin
          v_q   <= v_d;
          c_q   <= c_d;
          a_q   <= a_d;
          b_q   <= b_d;
          sum_q <= sum_d;
        end
      end

      assign v_s[k+1]   = v_q;
      assign c_s[k+1]   = c_q;
      assign a_s[k+1]   = a_q;
      assign b_s[k+1]   = b_q;
      assign sum_s[k+1] = sum_q;
    end else begin : g_last
      always_comb begin
        last_sum = sum_s[k];
        last_sum[LO +: CHUNK] = slice_s;
      end
      assign last_v  = v_s[k];
      assign last_co = co;
      assign last_cm = cm;
    end
  end

  // Output register: the final stage's result, flags and valid.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s_q,         s_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;
`ifdef RCA_PIPE_FLAGS_EN
  logic             zero_q,      zero_d;
  logic             neg_q,       neg_d;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
`ifdef RCA_PIPE_FLAGS_EN
    zero_d      = zero_q;
    neg_d       = neg_q;
`endif
    if (adv_c) begin
      out_valid_d = last_v;
      if (last_v) begin
        s_d    = last_sum;
        cout_d = last_co;
        ovf_d  = last_co ^ last_cm;
`ifdef RCA_PIPE_FLAGS_EN
        zero_d = (last_sum == '0);
        neg_d  = last_sum[WIDTH-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef RCA_PIPE_FLAGS_EN
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
`ifdef RCA_PIPE_FLAGS_EN
      zero_q      <= zero_d;
      neg_q       <= neg_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
`ifdef RCA_PIPE_FLAGS_EN
  assign zero      = zero_q;
  assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Directed bench for rca_pipe at default parameters (WIDTH=32, CHUNK=8, latency 4).
module tb_rca_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        cout;
  logic        ovf;
`ifdef RCA_PIPE_FLAGS_EN
  logic        zero;
  logic        neg;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rca_pipe #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
`ifdef RCA_PIPE_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: 33-bit two's-complement add of a and the effective b.
  function automatic logic [33:0] model(input logic [31:0] aa, input logic [31:0] bb,
                                        input logic ci, input logic sb);
    logic [31:0] be;
    logic [32:0] r;
    logic        c0;
    be = sb ? ~bb : bb;
    c0 = sb ? 1'b1 : ci;
    r  = {1'b0, aa} + {1'b0, be} + 33'(c0);
    return {r[32], (aa[31] == be[31]) && (r[31] != aa[31]), r[31:0]};
  endfunction

  task automatic drive(input logic [31:0] aa, input logic [31:0] bb, input logic ci, input logic sb);
    a = aa; b = bb; cin = ci; sub = sb; in_valid = 1'b1;
  endtask

  // Issue one op into an empty pipe, measure latency, check the result.
  task automatic run_one(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                         input logic ci, input logic sb,
                         input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    out_ready = 1'b1;
    drive(aa, bb, ci, sb);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"},  64'(lat),  64'd4);
    check({tag, "_s"},    64'(s),    64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"},  64'(ovf),  64'(eo));
`ifdef RCA_PIPE_FLAGS_EN
    check({tag, "_zero"}, 64'(zero), 64'(es == 32'd0));
    check({tag, "_neg"},  64'(neg),  64'(es[31]));
`endif
    step();
  endtask

  logic [31:0] ta [100];
  logic [31:0] tb_v [100];
  logic        tc [100];
  logic        tsb [100];
  logic [33:0] texp [100];
  logic [31:0] pa [5];
  logic [31:0] pb [5];
  logic        psb [5];
  logic [33:0] pexp [5];

  initial begin
    int j;
    int lat;
    bit seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s",         64'(s),         64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    step();
    rst_n = 1'b1;
    step();

    // Directed arithmetic, hand-computed.
    run_one("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("sub_zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_one("add_cin",    32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
    run_one("add_chunks", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
    run_one("sub_eq",     32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_one("sub_m1",     32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset with one result showing and three ops in flight.
    out_ready = 1'b1;
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
    step();
    step();
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_s",     64'(s),         64'hFFFF_FFFE);
    check("pre_rst_cout",  64'(cout),      64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    64'(out_valid), 64'd0);
    check("mid_rst_s",        64'(s),         64'd0);
    check("mid_rst_cout",     64'(cout),      64'd0);
    check("mid_rst_in_ready", 64'(in_ready),  64'd1);
    step();
    step();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    check("post_rst_flushed", 64'(seen_valid), 64'd0);
    run_one("post_rst_op", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Back-to-back throughput against the reference model.
    for (int i = 0; i < 100; i++) begin
      ta[i]   = $urandom();
      tb_v[i] = $urandom();
      tc[i]   = 1'($urandom_range(1));
      tsb[i]  = 1'($urandom_range(1));
      texp[i] = model(ta[i], tb_v[i], tc[i], tsb[i]);
    end
    out_ready = 1'b1;
    j = 0;
    for (int c = 0; c < 105; c++) begin
      if (c < 100) drive(ta[c], tb_v[c], tc[c], tsb[c]);
      else in_valid = 1'b0;
      if (c < 100 && !in_ready) check("tput_in_ready", 64'(in_ready), 64'd1);
      step();
      check("tput_out_valid", 64'(out_valid), 64'((c >= 3) && (c < 103)));
      if (out_valid && j < 100) begin
        check("tput_result", {30'd0, cout, ovf, s}, 64'(texp[j]));
        j++;
      end
    end
    check("tput_count", 64'(j), 64'd100);

    // Backpressure: fill, stall five cycles, release with simultaneous accept and emit.
    pa[0] = 32'hDEAD_BEEF; pb[0] = 32'h0000_0011; psb[0] = 1'b1;
    pa[1] = 32'h8000_0000; pb[1] = 32'h8000_0000; psb[1] = 1'b0;
    pa[2] = 32'h0000_0010; pb[2] = 32'h0000_0020; psb[2] = 1'b1;
    pa[3] = 32'h1234_0000; pb[3] = 32'h0000_4321; psb[3] = 1'b0;
    pa[4] = 32'h7FFF_FFFF; pb[4] = 32'hFFFF_FFFF; psb[4] = 1'b1;
    for (int i = 0; i < 5; i++) pexp[i] = model(pa[i], pb[i], 1'b0, psb[i]);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(pa[i], pb[i], 1'b0, psb[i]);
      step();
    end
    drive(pa[4], pb[4], 1'b0, psb[4]);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready),  64'd0);
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_hold_s",   {30'd0, cout, ovf, s}, 64'(pexp[0]));
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_s",        {30'd0, cout, ovf, s}, 64'(pexp[0]));
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      check("bp_drain_valid", 64'(out_valid), 64'd1);
      check("bp_drain_s",     {30'd0, cout, ovf, s}, 64'(pexp[k]));
      step();
    end
    check("bp_no_dup", 64'(out_valid), 64'd0);

    // Stall during the accept edge must not consume the held input.
    out_ready = 1'b0;
    drive(32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("stall_lat", 64'(lat), 64'd4);
    check("stall_s",   64'(s),   64'd5);
    out_ready = 1'b1;
    step();
    check("stall_drained", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_pipe.md
# rca_pipe

Parametrised, pipelined ripple-carry adder/subtractor. Successor to the fixed 16-bit chained adder in the ALU datapath. Operands are split into CHUNK-bit slices; each pipeline stage ripples one slice and registers the inter-slice carry, so the clock period is bounded by one slice. Valid/ready handshakes on both sides let the ALU issue one operation per cycle under backpressure.

## Interface
- WIDTH, 32: operand width; must be a multiple of CHUNK.
- CHUNK, 8: bits added per stage; STAGES = WIDTH/CHUNK.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  stage 0 accepts this cycle
- a, b  input  WIDTH  operands
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: a+b+cin; 1: a-b (a+~b+1)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- s  output  WIDTH  result
- cout  output  1  carry out of MSB (for subtraction: 1 = no borrow)
- ovf  output  1  signed overflow

## Operation
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv. The whole pipe moves together; there are no bubbles-collapse.
- Input transfer when in_valid && in_ready. Stage 0 captures b_eff = sub ? ~b : b, c0 = sub ? 1 : cin, adds slice 0, and registers sum slice 0, carry, remaining operand slices and valid.
- Stage k (1..STAGES-1) adds slice k of the skewed operands with the registered carry and appends its sum slice. Lower slices travel alongside in registers, so no output deskew is needed.
- The last stage registers s, cout = carry from bit WIDTH-1, and ovf = carry into MSB XOR carry out of MSB.
- When adv=0, all stage registers hold, including valids. in_valid without in_ready is not consumed; the producer holds.
- Arithmetic is modulo 2^WIDTH. a=b=0 with sub=1 gives s=0, cout=1, ovf=0.
- Simultaneous out_ready and in_valid at a full pipe: the result leaves and the new op enters in the same cycle, sustaining throughput 1/cycle.

## Timing
- Latency: STAGES cycles from input transfer to out_valid when unstalled (4 at defaults).
- Throughput: 1 op/cycle with out_ready held high.
- Reset (asynchronous, any time, including mid-operation): all stage valids=0, out_valid=0, s=0, cout=0, ovf=0, flag outputs=0. In-flight ops are discarded. in_ready=1 during and after reset (out_valid=0).
- No state machine; each stage is a valid bit plus data.
- STAGES=1 (CHUNK=WIDTH) is legal and gives a single-cycle registered adder.

## Configuration
- RCA_PIPE_FLAGS_EN defined: adds outputs zero (s==0) and neg (s[WIDTH-1]), registered in the last stage with s, reset to 0.
- RCA_PIPE_FLAGS_EN undefined: the ports and logic are absent; everything else is identical.

## Structure
- Package rca_pkg: the localparam rule for STAGES, the op encoding constants (OP_ADD=0, OP_SUB=1), and a slice-index helper function.
- Sub-module rca_chunk: combinational CHUNK-bit ripple adder (a, b, ci → s, co, plus the carry into its MSB, used for ovf). Instantiated once per stage by a generate loop.
- Elaboration check: WIDTH % CHUNK != 0 is a fatal error.

## Test plan
- Reset: assert rst_n=0 mid-stream with 3 ops in flight → out_valid=0, s=0 immediately. After release, the first new op appears exactly 4 cycles after acceptance.
- Add: a=32'hFFFF_FFFF, b=1, cin=0, sub=0 → after 4 cycles s=0, cout=1, ovf=0. a=32'h7FFF_FFFF, b=1 → s=32'h8000_0000, ovf=1.
- Subtract: a=5, b=7, sub=1 (cin=1 ignored) → s=32'hFFFF_FFFE, cout=0, ovf=0. a=32'h8000_0000, b=1 → s=32'h7FFF_FFFF, ovf=1.
- Throughput: 100 back-to-back random ops with out_ready=1 → 100 results in order on consecutive cycles, matching the reference model.
- Backpressure: out_ready low for 5 cycles while the pipe is full → in_ready=0, s held stable. On release, a simultaneous accept and emit occurs in the same cycle with no loss or duplication.
- Flags (RCA_PIPE_FLAGS_EN): a=3, b=3, sub=1 → zero=1, neg=0. a=0, b=1, sub=1 → zero=0, neg=1. WIDTH=16, CHUNK=16 build → latency 1.
